// File: rtl/mem_access_unit_if.sv
// Purpose : pipeline-request / word-memory bus seen by mem_access_unit.
// Ports   : req_* pipeline request, stall/rdata/rdata_valid/access_err response,
//           mem_* single-ported word memory (ren/wen/addr/din, combinational dout).
//           slave = the access unit, master = pipeline plus memory side.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_read;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        access_err;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    modport slave (
        input  req_valid, req_read, req_write, req_size, req_unsigned,
               req_addr, req_wdata, mem_dout,
        output stall, rdata, rdata_valid, access_err,
               mem_ren, mem_wen, mem_addr, mem_din
    );

    modport master (
        output req_valid, req_read, req_write, req_size, req_unsigned,
               req_addr, req_wdata, mem_dout,
        input  stall, rdata, rdata_valid, access_err,
               mem_ren, mem_wen, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_access_unit.sv
// Purpose : MEM-stage initiator turning lw/lh/lhu/lb/lbu/sw/sh/sb requests into
//           single-ported word-memory transactions (sub-word stores by read-modify-write).
// Ports   : clock, reset (sync, active-high); bus (mem_access_unit_if.slave) carrying
//           the pipeline request/response and the memory ren/wen/addr/din/dout signals.
module mem_access_unit #(
    parameter int unsigned MEM_WORDS_LOG2 = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    mem_access_unit_if.slave     bus
);
    localparam int unsigned AW = MEM_WORDS_LOG2 + 2;   // in-range byte-address width

    typedef enum logic [2:0] {
        S_IDLE, S_LD, S_WR, S_RMW_RD, S_RMW_WR, S_RESP
    } state_e;

    state_e         state_q;
    logic [AW-1:0]  addr_q;
    logic [1:0]     size_q;
    logic           uns_q;
    logic [31:0]    wdata_q;
    logic [31:0]    merge_q;
    logic [31:0]    rdata_q;
    logic           rvalid_q;
    logic           err_q;

    logic           accept_c;
    logic           req_err_c;
    logic [7:0]     lane_b_c;
    logic [15:0]    lane_h_c;
    logic [31:0]    load_c;
    logic [31:0]    merge_c;
    logic           wen_c;

    assign accept_c = (state_q == S_IDLE) && bus.req_valid && (bus.req_read || bus.req_write);

    // Request legality, checked in priority order.
    always_comb begin
        req_err_c = 1'b0;
        if (bus.req_read && bus.req_write)                      req_err_c = 1'b1;
        else if (bus.req_size == 2'd3)                          req_err_c = 1'b1;
        else if (bus.req_size == 2'd1 && bus.req_addr[0])       req_err_c = 1'b1;
        else if (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'b00) req_err_c = 1'b1;
        else if (bus.req_addr[31:AW] != '0)                     req_err_c = 1'b1;
    end

    // Little-endian lane extraction and sign/zero extension for loads.
    assign lane_b_c = 8'(bus.mem_dout >> {addr_q[1:0], 3'b000});
    assign lane_h_c = 16'(bus.mem_dout >> {addr_q[1], 4'b0000});

    always_comb begin
        case (size_q)
            2'd0:    load_c = uns_q ? {24'd0, lane_b_c} : {{24{lane_b_c[7]}}, lane_b_c};
            2'd1:    load_c = uns_q ? {16'd0, lane_h_c} : {{16{lane_h_c[15]}}, lane_h_c};
            default: load_c = bus.mem_dout;
        endcase
    end

    // Read-modify-write merge: replace the addressed byte/half in the fetched word.
    always_comb begin
        merge_c = bus.mem_dout;
        if (size_q == 2'd0)
            merge_c[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merge_c[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            size_q   <= 2'd0;
            uns_q    <= 1'b0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        addr_q  <= bus.req_addr[AW-1:0];
                        size_q  <= bus.req_size;
                        uns_q   <= bus.req_unsigned;
                        wdata_q <= bus.req_wdata;
                        if (req_err_c) begin
                            err_q    <= 1'b1;
                            rdata_q  <= '0;
                            rvalid_q <= 1'b1;
                            state_q  <= S_RESP;
                        end else if (bus.req_read) begin
                            state_q <= S_LD;
                        end else if (bus.req_size == 2'd2) begin
                            state_q <= S_WR;
                        end else begin
                            state_q <= S_RMW_RD;
                        end
                    end
                end
                S_LD: begin
                    rdata_q  <= load_c;
                    rvalid_q <= 1'b1;
                    state_q  <= S_RESP;
                end
                S_WR: begin
                    rvalid_q <= 1'b1;
                    state_q  <= S_RESP;
                end
                S_RMW_RD: begin
                    merge_q <= merge_c;
                    state_q <= S_RMW_WR;
                end
                S_RMW_WR: begin
                    rvalid_q <= 1'b1;
                    state_q  <= S_RESP;
                end
                S_RESP: begin
                    err_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Memory strobes decode from state only; wen is also held off while reset is high.
    assign wen_c = ((state_q == S_WR) || (state_q == S_RMW_WR)) && !reset;

    assign bus.mem_ren  = (state_q == S_LD) || (state_q == S_RMW_RD);
    assign bus.mem_wen  = wen_c;
    assign bus.mem_addr = (state_q == S_IDLE) ? 32'd0 : 32'(addr_q[AW-1:2]);
    assign bus.mem_din  = !wen_c ? 32'd0 : ((state_q == S_WR) ? wdata_q : merge_q);

    // Combinational so the accepting cycle already freezes the pipeline.
    assign bus.stall = accept_c || (state_q == S_LD) || (state_q == S_WR) ||
                       (state_q == S_RMW_RD) || (state_q == S_RMW_WR);

    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rvalid_q;
    assign bus.access_err  = err_q;
endmodule
